// File: rtl/frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_pkg
// Description : Shared constants, FSM state encodings and sizing helper
// Revision    : 1.0 - initial release
// ============================================================================
package frame_pkg;

    localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hCAFE;
    localparam logic [31:0] DEFAULT_SEED      = 32'h01F97414;

    typedef logic [2:0] tx_state_t;
    localparam tx_state_t TX_IDLE = 3'd0;
    localparam tx_state_t TX_HDR  = 3'd1;
    localparam tx_state_t TX_LOAD = 3'd2;
    localparam tx_state_t TX_DATA = 3'd3;
    localparam tx_state_t TX_GAP  = 3'd4;
    localparam tx_state_t TX_WAIT = 3'd5;

    typedef logic [2:0] rx_state_t;
    localparam rx_state_t RX_IDLE = 3'd0;
    localparam rx_state_t RX_HUNT = 3'd1;
    localparam rx_state_t RX_SEQ  = 3'd2;
    localparam rx_state_t RX_DATA = 3'd3;
    localparam rx_state_t RX_EMIT = 3'd4;

    function automatic int sample_bytes(input int sample_w);
        return sample_w / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_manager_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_manager_if
// Description : SPI byte transceiver and cipher/keystream bus of the framer
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_manager_if #(
    parameter int SAMPLE_W = 16
);
    logic                spi_tx_start;
    logic [7:0]          spi_tx_data;
    logic                spi_tx_busy;
    logic [7:0]          spi_rx_data;
    logic                spi_rx_done;
    logic [SAMPLE_W-1:0] encrypt_data_out;
    logic [SAMPLE_W-1:0] tx_data_in;
    logic [SAMPLE_W-1:0] spi_rx_assembled;
    logic [SAMPLE_W-1:0] decrypt_data_in;
    logic                next_key_en;
    logic                sync_en;
    logic [31:0]         sync_state_out;

    modport master (
        output spi_tx_start, spi_tx_data, encrypt_data_out, spi_rx_assembled,
               next_key_en, sync_en, sync_state_out,
        input  spi_tx_busy, spi_rx_data, spi_rx_done, tx_data_in, decrypt_data_in
    );

    modport slave (
        input  spi_tx_start, spi_tx_data, encrypt_data_out, spi_rx_assembled,
               next_key_en, sync_en, sync_state_out,
        output spi_tx_busy, spi_rx_data, spi_rx_done, tx_data_in, decrypt_data_in
    );
endinterface
`default_nettype wire

// File: rtl/frame_manager_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo
// Description : First-word-fall-through sample FIFO with synchronous flush
// Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo #(
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                wr,
    input  wire logic [SAMPLE_W-1:0] wr_data,
    input  wire logic                rd,
    output logic      [SAMPLE_W-1:0] rd_data,
    input  wire logic                flush,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [SAMPLE_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]         r_wr_ptr;
    logic [AW:0]         r_rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (wr && !full)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (rd && !empty)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr && !full && !flush)
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/frame_manager.sv
`default_nettype none
// ============================================================================
// Module      : frame_manager
// Description : Framed encrypted-audio TX/RX over a byte-wide SPI transceiver
// Revision    : 1.0 - initial release
// ============================================================================
module frame_manager
    import frame_pkg::*;
#(
    parameter int          SAMPLE_W   = 16,
    parameter int          FRAME_LEN  = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] SYNC_WORD  = DEFAULT_SYNC_WORD,
    parameter logic [31:0] SEED       = DEFAULT_SEED,
    parameter int          RX_TIMEOUT = 1024
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                push_to_talk,
    input  wire logic [SAMPLE_W-1:0] adc_data_in,
    input  wire logic                adc_data_valid,
    output logic      [SAMPLE_W-1:0] dac_data_out,
    output logic                     dac_data_valid,
    frame_manager_if.master          bus,
    output logic                     tx_overflow,
    output logic                     rx_locked,
    output logic      [7:0]          rx_err_count
);
    localparam int             BYTES          = sample_bytes(SAMPLE_W);
    localparam int             TW             = $clog2(RX_TIMEOUT + 1);
    localparam logic [2:0]     c_last_byte    = 3'(BYTES - 1);
    localparam logic [7:0]     c_last_sample  = 8'(FRAME_LEN - 1);
    localparam logic [TW-1:0]  c_timeout_last = TW'(RX_TIMEOUT - 1);

    tx_state_t           r_tx_state;
    logic [2:0]          r_tx_idx;
    logic                r_in_hdr;
    logic [7:0]          r_tx_cnt;
    logic [7:0]          r_tx_seq;
    logic [SAMPLE_W-1:0] r_tx_word;
    logic                r_tx_start;
    logic [7:0]          r_tx_data;
    logic                r_tx_sync;
    logic                r_tx_key;
    logic                r_ptt_d;
    logic                r_overflow;

    logic                w_full, w_empty, w_fifo_wr, w_fifo_rd, w_flush, w_load_go;
    logic [SAMPLE_W-1:0] w_fifo_data;
    logic [7:0]          w_hdr_byte;

    assign w_fifo_wr = push_to_talk && adc_data_valid && !w_full;
    assign w_fifo_rd = (r_tx_state == TX_LOAD) && !w_empty;
    assign w_flush   = !push_to_talk && (r_tx_state == TX_IDLE);
    // An empty FIFO stalls LOAD only while talking; otherwise a zero sample pads the frame.
    assign w_load_go = (r_tx_state == TX_LOAD) && (!w_empty || !push_to_talk);

    sample_fifo #(
        .SAMPLE_W   (SAMPLE_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (w_fifo_wr),
        .wr_data (adc_data_in),
        .rd      (w_fifo_rd),
        .rd_data (w_fifo_data),
        .flush   (w_flush),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_comb begin
        w_hdr_byte = r_tx_seq;
        case (r_tx_idx)
            3'd0:    w_hdr_byte = SYNC_WORD[15:8];
            3'd1:    w_hdr_byte = SYNC_WORD[7:0];
            default: w_hdr_byte = r_tx_seq;
        endcase
    end

    assign bus.encrypt_data_out = w_fifo_rd ? w_fifo_data : '0;
    assign bus.spi_tx_start     = r_tx_start;
    assign bus.spi_tx_data      = r_tx_data;
    assign bus.sync_state_out   = SEED;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptt_d    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_ptt_d <= push_to_talk;
            if (push_to_talk && !r_ptt_d)
                r_overflow <= 1'b0;
            if (push_to_talk && adc_data_valid && w_full)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_idx   <= '0;
            r_in_hdr   <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_seq   <= '0;
            r_tx_word  <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_tx_sync  <= 1'b0;
            r_tx_key   <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_tx_sync  <= 1'b0;
            r_tx_key   <= 1'b0;
            case (r_tx_state)
                TX_IDLE: if (push_to_talk && !w_empty) begin
                    r_tx_sync  <= 1'b1;
                    r_tx_idx   <= '0;
                    r_in_hdr   <= 1'b1;
                    r_tx_cnt   <= '0;
                    r_tx_state <= TX_HDR;
                end
                TX_HDR: begin
                    r_tx_start <= 1'b1;
                    r_tx_data  <= w_hdr_byte;
                    r_tx_state <= TX_GAP;
                end
                TX_LOAD: if (w_load_go) begin
                    r_tx_word  <= bus.tx_data_in;
                    r_tx_key   <= 1'b1;
                    r_tx_idx   <= '0;
                    r_tx_state <= TX_DATA;
                end
                TX_DATA: begin
                    r_tx_start <= 1'b1;
                    r_tx_data  <= r_tx_word[SAMPLE_W-1 -: 8];
                    r_tx_word  <= r_tx_word << 8;
                    r_tx_state <= TX_GAP;
                end
                // The transceiver may not raise busy until a cycle after start.
                TX_GAP: r_tx_state <= TX_WAIT;
                TX_WAIT: if (!bus.spi_tx_busy) begin
                    if (r_in_hdr) begin
                        if (r_tx_idx == 3'd2) begin
                            r_in_hdr   <= 1'b0;
                            r_tx_state <= TX_LOAD;
                        end else begin
                            r_tx_idx   <= r_tx_idx + 3'd1;
                            r_tx_state <= TX_HDR;
                        end
                    end else if (r_tx_idx != c_last_byte) begin
                        r_tx_idx   <= r_tx_idx + 3'd1;
                        r_tx_state <= TX_DATA;
                    end else if (r_tx_cnt == c_last_sample) begin
                        r_tx_seq   <= r_tx_seq + 8'd1;
                        r_tx_state <= TX_IDLE;
                    end else begin
                        r_tx_cnt   <= r_tx_cnt + 8'd1;
                        r_tx_state <= TX_LOAD;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    rx_state_t           r_rx_state;
    logic [15:0]         r_window;
    logic [2:0]          r_rx_idx;
    logic [7:0]          r_rx_cnt;
    logic [7:0]          r_exp_seq;
    logic                r_seq_check;
    logic [TW-1:0]       r_rx_timer;
    logic [SAMPLE_W-1:0] r_rx_asm;
    logic [SAMPLE_W-1:0] r_dac_data;
    logic                r_dac_valid;
    logic                r_rx_sync;
    logic                r_rx_key;
    logic                r_locked;
    logic [7:0]          r_err;

    logic [15:0]         w_window_next;
    logic [SAMPLE_W-1:0] w_asm_next;
    logic [7:0]          w_err_inc;
    logic                w_timeout;

    assign w_window_next = {r_window[7:0], bus.spi_rx_data};
    assign w_asm_next    = (r_rx_asm << 8) | SAMPLE_W'(bus.spi_rx_data);
    assign w_err_inc     = (r_err == 8'hFF) ? r_err : r_err + 8'd1;
    assign w_timeout     = !bus.spi_rx_done && (r_rx_timer == c_timeout_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state  <= RX_IDLE;
            r_window    <= '0;
            r_rx_idx    <= '0;
            r_rx_cnt    <= '0;
            r_exp_seq   <= '0;
            r_seq_check <= 1'b0;
            r_rx_timer  <= '0;
            r_rx_asm    <= '0;
            r_dac_data  <= '0;
            r_dac_valid <= 1'b0;
            r_rx_sync   <= 1'b0;
            r_rx_key    <= 1'b0;
            r_locked    <= 1'b0;
            r_err       <= '0;
        end else begin
            r_dac_valid <= 1'b0;
            r_rx_sync   <= 1'b0;
            r_rx_key    <= 1'b0;
            if (push_to_talk && (r_rx_state != RX_IDLE)) begin
                r_rx_state <= RX_IDLE;
                r_locked   <= 1'b0;
                r_rx_idx   <= '0;
            end else begin
                case (r_rx_state)
                    RX_IDLE: begin
                        r_window <= '0;
                        if (!push_to_talk)
                            r_rx_state <= RX_HUNT;
                    end
                    RX_HUNT: if (bus.spi_rx_done) begin
                        r_window <= w_window_next;
                        if (w_window_next == SYNC_WORD) begin
                            r_rx_sync   <= 1'b1;
                            r_seq_check <= r_locked;
                            r_locked    <= 1'b1;
                            r_rx_timer  <= '0;
                            r_rx_state  <= RX_SEQ;
                        end
                    end
                    RX_SEQ, RX_DATA: begin
                        if (bus.spi_rx_done) begin
                            r_rx_timer <= '0;
                            if (r_rx_state == RX_SEQ) begin
                                if (r_seq_check && (bus.spi_rx_data != r_exp_seq))
                                    r_err <= w_err_inc;
                                r_exp_seq  <= bus.spi_rx_data + 8'd1;
                                r_rx_cnt   <= '0;
                                r_rx_idx   <= '0;
                                r_rx_state <= RX_DATA;
                            end else begin
                                r_rx_asm <= w_asm_next;
                                if (r_rx_idx == c_last_byte)
                                    r_rx_state <= RX_EMIT;
                                else
                                    r_rx_idx <= r_rx_idx + 3'd1;
                            end
                        end else if (w_timeout) begin
                            r_rx_state <= RX_HUNT;
                            r_locked   <= 1'b0;
                            r_window   <= '0;
                            r_err      <= w_err_inc;
                        end else begin
                            r_rx_timer <= r_rx_timer + 1'b1;
                        end
                    end
                    RX_EMIT: begin
                        r_dac_data  <= bus.decrypt_data_in;
                        r_dac_valid <= 1'b1;
                        r_rx_key    <= 1'b1;
                        r_rx_timer  <= '0;
                        // A byte landing in this cycle belongs to whatever comes next.
                        if (r_rx_cnt == c_last_sample) begin
                            r_window   <= bus.spi_rx_done ? {8'h00, bus.spi_rx_data} : 16'h0000;
                            r_rx_state <= RX_HUNT;
                        end else begin
                            r_rx_cnt <= r_rx_cnt + 8'd1;
                            if (bus.spi_rx_done) begin
                                r_rx_asm <= w_asm_next;
                                if (c_last_byte == 3'd0) begin
                                    r_rx_state <= RX_EMIT;
                                end else begin
                                    r_rx_idx   <= 3'd1;
                                    r_rx_state <= RX_DATA;
                                end
                            end else begin
                                r_rx_idx   <= '0;
                                r_rx_state <= RX_DATA;
                            end
                        end
                    end
                    default: r_rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    assign bus.spi_rx_assembled = r_rx_asm;
    assign bus.next_key_en      = r_tx_key | r_rx_key;
    assign bus.sync_en          = r_tx_sync | r_rx_sync;
    assign dac_data_out         = r_dac_data;
    assign dac_data_valid       = r_dac_valid;
    assign tx_overflow          = r_overflow;
    assign rx_locked            = r_locked;
    assign rx_err_count         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_frame_manager.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_manager
// Description : Directed self-checking bench for frame_manager (XOR-FFFF cipher)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_manager;
    import frame_pkg::*;

    localparam int SW = 16;
    localparam int FL = 2;
    localparam int FD = 4;
    localparam int TO = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ptt = 1'b0;
    logic [SW-1:0] adc_data = '0;
    logic          adc_valid = 1'b0;
    logic [SW-1:0] dac_data;
    logic          dac_valid;
    logic          tx_ovf;
    logic          locked;
    logic [7:0]    err_cnt;
    logic          force_busy = 1'b0;
    int            busy_cnt = 0;

    frame_manager_if #(.SAMPLE_W(SW)) bus ();

    frame_manager #(
        .SAMPLE_W   (SW),
        .FRAME_LEN  (FL),
        .FIFO_DEPTH (FD),
        .SYNC_WORD  (16'hCAFE),
        .SEED       (32'h01F97414),
        .RX_TIMEOUT (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .push_to_talk   (ptt),
        .adc_data_in    (adc_data),
        .adc_data_valid (adc_valid),
        .dac_data_out   (dac_data),
        .dac_data_valid (dac_valid),
        .bus            (bus),
        .tx_overflow    (tx_ovf),
        .rx_locked      (locked),
        .rx_err_count   (err_cnt)
    );

    always #5 clk = ~clk;

    assign bus.tx_data_in      = bus.encrypt_data_out ^ 16'hFFFF;
    assign bus.decrypt_data_in = bus.spi_rx_assembled ^ 16'hFFFF;
    assign bus.spi_tx_busy     = force_busy | (busy_cnt != 0);

    logic [7:0]    tx_log  [0:63];
    logic [SW-1:0] dac_log [0:31];
    int tx_n = 0, dac_n = 0, sync_n = 0, key_n = 0;

    // Transceiver model: logs each launched byte and stays busy for 3 clocks.
    always @(posedge clk) begin
        if (bus.spi_tx_start) begin
            tx_log[tx_n[5:0]] <= bus.spi_tx_data;
            tx_n              <= tx_n + 1;
            busy_cnt          <= 3;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (dac_valid) begin
            dac_log[dac_n[4:0]] <= dac_data;
            dac_n               <= dac_n + 1;
        end
        if (bus.sync_en)     sync_n <= sync_n + 1;
        if (bus.next_key_en) key_n  <= key_n + 1;
    end

    int n_checks = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [SW-1:0] d);
        adc_data  = d;
        adc_valid = 1'b1;
        @(negedge clk);
        adc_valid = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        bus.spi_rx_data = b;
        bus.spi_rx_done = 1'b1;
        @(negedge clk);
        bus.spi_rx_done = 1'b0;
        tick(2);
    endtask

    task automatic wait_tx(input int target, input int budget, input string tag);
        int k = 0;
        while (tx_n < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(tx_n >= target), 32'd1);
    endtask

    logic [7:0] exp_f0 [7]  = '{8'hCA, 8'hFE, 8'h00, 8'hED, 8'hCB, 8'hA9, 8'h87};
    logic [7:0] exp_f1 [5]  = '{8'h01, 8'h55, 8'h55, 8'hFF, 8'hFF};
    logic [7:0] exp_ov [14] = '{8'hCA, 8'hFE, 8'h02, 8'hFE, 8'hFE, 8'hFD, 8'hFD,
                                8'hCA, 8'hFE, 8'h03, 8'hFC, 8'hFC, 8'hFB, 8'hFB};
    logic [7:0] rx_f0 [8]   = '{8'h11, 8'hCA, 8'hFE, 8'h05, 8'hED, 8'hCB, 8'hA9, 8'h87};
    logic [7:0] rx_f1 [7]   = '{8'hCA, 8'hFE, 8'h07, 8'h00, 8'h00, 8'hFF, 8'hFF};

    initial begin
        int s, k, d, b;
        bus.spi_rx_data = 8'h00;
        bus.spi_rx_done = 1'b0;

        tick(3);
        check("rst_tx_start", 32'(bus.spi_tx_start), 32'd0);
        check("rst_sync_en",  32'(bus.sync_en), 32'd0);
        check("rst_key_en",   32'(bus.next_key_en), 32'd0);
        check("rst_seed",     bus.sync_state_out, 32'h01F97414);
        check("rst_dac_vld",  32'(dac_valid), 32'd0);
        check("rst_locked",   32'(locked), 32'd0);
        check("rst_err",      32'(err_cnt), 32'd0);
        check("rst_ovf",      32'(tx_ovf), 32'd0);
        check("rst_encrypt",  32'(bus.encrypt_data_out), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // TX frame with two samples
        s = sync_n; k = key_n;
        ptt = 1'b1;
        tick(1);
        push(16'h1234);
        push(16'h5678);
        wait_tx(7, 400, "tx0_done");
        tick(20);
        check("tx0_count", 32'(tx_n), 32'd7);
        for (int i = 0; i < 7; i++)
            check($sformatf("tx0_b%0d", i), 32'(tx_log[i]), 32'(exp_f0[i]));
        check("tx0_sync", 32'(sync_n - s), 32'd1);
        check("tx0_key",  32'(key_n - k), 32'd2);

        // Second frame carries the incremented sequence byte
        push(16'hAAAA);
        push(16'h0000);
        wait_tx(14, 400, "tx1_done");
        tick(20);
        for (int i = 0; i < 5; i++)
            check($sformatf("tx1_b%0d", i + 2), 32'(tx_log[i + 9]), 32'(exp_f1[i]));
        ptt = 1'b0;
        tick(3);

        // RX frame with a leading junk byte
        d = dac_n; s = sync_n; k = key_n;
        for (int i = 0; i < 8; i++) rx_byte(rx_f0[i]);
        tick(5);
        check("rx0_count",  32'(dac_n - d), 32'd2);
        check("rx0_s0",     32'(dac_log[5'(d)]), 32'h1234);
        check("rx0_s1",     32'(dac_log[5'(d + 1)]), 32'h5678);
        check("rx0_locked", 32'(locked), 32'd1);
        check("rx0_err",    32'(err_cnt), 32'd0);
        check("rx0_sync",   32'(sync_n - s), 32'd1);
        check("rx0_key",    32'(key_n - k), 32'd2);

        // Sequence gap: 05 followed by 07
        d = dac_n;
        for (int i = 0; i < 7; i++) rx_byte(rx_f1[i]);
        tick(5);
        check("gap_err",   32'(err_cnt), 32'd1);
        check("gap_count", 32'(dac_n - d), 32'd2);
        check("gap_s0",    32'(dac_log[5'(d)]), 32'hFFFF);
        check("gap_s1",    32'(dac_log[5'(d + 1)]), 32'h0000);

        // Timeout after SYNC + in-order seq
        rx_byte(8'hCA); rx_byte(8'hFE); rx_byte(8'h08);
        check("to_seq_ok", 32'(err_cnt), 32'd1);
        tick(10);
        check("to_early_locked", 32'(locked), 32'd1);
        tick(40);
        check("to_locked", 32'(locked), 32'd0);
        check("to_err",    32'(err_cnt), 32'd2);
        check("to_hunt",   32'(dut.r_rx_state), 32'(RX_HUNT));

        // PTT raised mid-sample
        d = dac_n;
        rx_byte(8'hCA); rx_byte(8'hFE); rx_byte(8'h09); rx_byte(8'hED);
        check("ab_locked_pre", 32'(locked), 32'd1);
        ptt = 1'b1;
        tick(1);
        check("ab_idle",   32'(dut.r_rx_state), 32'(RX_IDLE));
        check("ab_locked", 32'(locked), 32'd0);
        tick(5);
        check("ab_no_dac", 32'(dac_n - d), 32'd0);
        check("ab_err",    32'(err_cnt), 32'd2);
        ptt = 1'b0;
        tick(3);

        // Overflow: six samples into a depth-4 FIFO while the link is busy
        b = tx_n;
        force_busy = 1'b1;
        ptt = 1'b1;
        tick(1);
        check("ov_clear_pre", 32'(tx_ovf), 32'd0);
        for (int i = 1; i <= 6; i++) push(16'(i * 16'h0101));
        check("ov_set", 32'(tx_ovf), 32'd1);
        tick(10);
        check("ov_sticky", 32'(tx_ovf), 32'd1);
        force_busy = 1'b0;
        wait_tx(b + 14, 800, "ov_done");
        tick(40);
        check("ov_lost", 32'(tx_n - b), 32'd14);
        for (int i = 0; i < 14; i++)
            check($sformatf("ov_b%0d", i), 32'(tx_log[6'(b + i)]), 32'(exp_ov[i]));
        ptt = 1'b0;
        tick(2);
        ptt = 1'b1;
        tick(2);
        check("ov_cleared", 32'(tx_ovf), 32'd0);

        // Asynchronous reset in the middle of a TX frame
        b = tx_n;
        push(16'h1111);
        push(16'h2222);
        wait_tx(b + 3, 300, "rst_mid_frame");
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_tx_start", 32'(bus.spi_tx_start), 32'd0);
        check("ar_tx_data",  32'(bus.spi_tx_data), 32'd0);
        check("ar_key_en",   32'(bus.next_key_en), 32'd0);
        check("ar_sync_en",  32'(bus.sync_en), 32'd0);
        check("ar_err",      32'(err_cnt), 32'd0);
        check("ar_asm",      32'(bus.spi_rx_assembled), 32'd0);
        check("ar_encrypt",  32'(bus.encrypt_data_out), 32'd0);
        check("ar_seed",     bus.sync_state_out, 32'h01F97414);
        b = tx_n;
        tick(5);
        check("ar_no_start", 32'(tx_n - b), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
